// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream logic.
// The occupancy encoding doubles as the entry count (0, 1, 2).
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer with occupancy FSM; head entry drives the stream.
// The FSM state is exported on state_o so checkers can observe occupancy directly.
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_i,
    input  logic [DATA_SIZE-1:0] push_data_i,
    input  logic                 pop_i,
    output logic                 valid_o,
    output logic [DATA_SIZE-1:0] data_o,
    output occ_state_t           state_o
);

    occ_state_t           state_q, state_d;
    logic [DATA_SIZE-1:0] head_q, head_d;
    logic [DATA_SIZE-1:0] tail_q, tail_d;
    logic                 pop;

    assign pop = pop_i && (state_q != OCC_EMPTY);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= OCC_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    state_d = OCC_ONE;
                    head_d  = push_data_i;
                end
            end
            OCC_ONE: begin
                case ({push_i, pop})
                    2'b10: begin
                        state_d = OCC_TWO;
                        tail_d  = push_data_i;
                    end
                    2'b01: state_d = OCC_EMPTY;
                    // Capture and transfer together: new word replaces head, no bubble.
                    2'b11: head_d = push_data_i;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                // The pop-issue logic never lets a push arrive here without a pop.
                if (pop) begin
                    head_d = tail_q;
                    if (push_i) begin
                        tail_d = push_data_i;
                    end else begin
                        state_d = OCC_ONE;
                    end
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
    end

    assign valid_o = (state_q != OCC_EMPTY);
    assign data_o  = head_q;
    assign state_o = state_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops words from a synchronous FIFO (1-cycle read latency) and presents them as a
// valid/ready stream at up to one word per clock, counting delivered words.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fifo_empty_i,
    input  logic [DATA_SIZE-1:0] fifo_data_i,
    output logic                 fifo_rd_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_SIZE-1:0] m_data_o,
    output logic [CNT_W-1:0]     words_o
);

    // Stream handshake: a word transfers on every clk where m_valid_o && m_ready_i;
    // once m_valid_o rises, m_valid_o and m_data_o hold until that transfer happens.

    occ_state_t       occ_state;
    logic             inflight_q;
    logic             xfer;
    logic [1:0]       pending;
    logic [CNT_W-1:0] words_q;

    assign xfer    = m_valid_o && m_ready_i;
    // Buffered words plus the word still coming out of the FIFO; never exceeds 2.
    assign pending = 2'(occ_state) + {1'b0, inflight_q};

    assign fifo_rd_o = !rst_i && !fifo_empty_i &&
                       ((pending < 2'd2) || ((pending == 2'd2) && xfer));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            words_q    <= '0;
        end else begin
            inflight_q <= fifo_rd_o;
            if (xfer) begin
                words_q <= words_q + CNT_W'(1);
            end
        end
    end

    fifo_rd_skid #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (fifo_data_i),
        .pop_i       (xfer),
        .valid_o     (m_valid_o),
        .data_o      (m_data_o),
        .state_o     (occ_state)
    );

    assign words_o = words_q;

endmodule
